uart_rx_cfg: RTL and testbench

Parametrised UART receiver replacing the fixed 8N1 receiver on the host command link. It accepts configurable data width, parity and stop bits. It samples each bit with 16x (configurable) oversampling and a 3-sample majority vote, and rejects start-bit glitches. Per-word framing, parity and break status travel with the data. Received words are delivered to the command decoder over a valid/ready stream, with optional FIFO buffering.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_cfg.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state type and divider helper
// for the configurable UART receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // {break, parity_err, frame_err} carried beside the data bits
  localparam int STAT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } state_t;

  function automatic int baud_div(
    input int clk_hz,
    input int bps,
    input int os
  );
    return clk_hz / (bps * os);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with occupancy count.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = empty ? '0 : mem[rd_ptr];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with configurable framing and majority-vote sampling.
// Define UART_RX_CFG_FIFO_EN to buffer words in uart_rx_fifo instead of one register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_frame_err,
  output logic                 m_parity_err,
  output logic                 m_break,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun
);
  localparam int BAUD_DIV = baud_div(CLK_FREQ, UART_BPS, OVERSAMPLE);
  localparam int DVW = $clog2(BAUD_DIV + 1);
  localparam int PW  = $clog2(OVERSAMPLE);
  localparam int CW  = $clog2(OVERSAMPLE + 1);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam int WW  = STAT_W + DATA_BITS;

  localparam logic [DVW-1:0] DIV_LAST = DVW'(BAUD_DIV - 1);
  localparam logic [PW-1:0]  PH_S0    = PW'(OVERSAMPLE/2 - 1);
  localparam logic [PW-1:0]  PH_S1    = PW'(OVERSAMPLE/2);
  localparam logic [PW-1:0]  PH_DEC   = PW'(OVERSAMPLE/2 + 1);
  localparam logic [PW-1:0]  PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]  HI_FULL  = CW'(OVERSAMPLE);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(DATA_BITS);

  state_t               state, nstate;
  logic [1:0]           sync_q;
  logic                 rx_s, rx_d, fall;
  logic [DVW-1:0]       div_cnt;
  logic [PW-1:0]        phase;
  logic                 tick, wrap, dec_now, dec;
  logic                 samp0, samp1;
  logic [BCW-1:0]       bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q, ferr_q, zero_q;
  logic [CW-1:0]        hi_cnt;
  logic                 par_ref, stop_final;
  logic                 commit, c_ferr, c_brk;
  logic [WW-1:0]        c_word, head;

  assign rx_s       = sync_q[1];
  assign fall       = rx_d & ~rx_s;
  assign tick       = (state != ST_IDLE) && (div_cnt == DIV_LAST);
  assign wrap       = tick && (phase == PH_LAST);
  assign dec_now    = tick && (phase == PH_DEC);
  assign dec        = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign par_ref    = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
  assign stop_final = dec_now && ((STOP_BITS == 1) || stop_cnt);
  assign c_word     = {c_brk, perr_q, c_ferr, shreg};

  // line synchroniser and previous-value register for edge detect
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= 2'b11;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      rx_d   <= rx_s;
    end
  end

  // oversampling tick divider and bit phase, parked at zero while idle
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state == ST_IDLE) begin
      div_cnt <= '0;
      phase   <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DVW'(1);
      if (tick) phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= nstate;
  end

  // FSM next-state logic; states advance on the bit boundary
  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE:     if (fall) nstate = ST_START;
      ST_START:    if (dec_now && dec) nstate = ST_IDLE;
                   else if (wrap) nstate = ST_DATA;
      ST_DATA:     if (wrap && bit_cnt == BC_LAST)
                     nstate = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY:   if (wrap) nstate = ST_STOP;
      ST_STOP:     if (stop_final) nstate = c_brk ? ST_BRK_WAIT : ST_IDLE;
      ST_BRK_WAIT: if (hi_cnt == HI_FULL) nstate = ST_IDLE;
      default:     nstate = ST_IDLE;
    endcase
  end

  // FSM outputs: commit the word at the final stop decision
  always_comb begin
    c_ferr = ferr_q | ~dec;
    c_brk  = zero_q & ~dec;
    commit = (state == ST_STOP) && stop_final;
  end

  // sampling, shift register and per-frame status accumulation
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      samp0    <= 1'b1;
      samp1    <= 1'b1;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      zero_q   <= 1'b1;
      hi_cnt   <= '0;
    end else begin
      if (tick && phase == PH_S0) samp0 <= rx_s;
      if (tick && phase == PH_S1) samp1 <= rx_s;
      if (state == ST_IDLE) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        perr_q   <= 1'b0;
        ferr_q   <= 1'b0;
        zero_q   <= 1'b1;
      end
      if (dec_now) begin
        case (state)
          ST_DATA: begin
            for (int i = 0; i < DATA_BITS; i++)
              if (bit_cnt == BCW'(i)) shreg[i] <= dec;
            bit_cnt <= bit_cnt + BCW'(1);
            if (dec) zero_q <= 1'b0;
          end
          ST_PARITY: begin
            perr_q <= (dec != par_ref);
            if (dec) zero_q <= 1'b0;
          end
          ST_STOP: begin
            stop_cnt <= 1'b1;
            ferr_q   <= ~dec;
            if (dec) zero_q <= 1'b0;
          end
          default: ;
        endcase
      end
      if (state != ST_BRK_WAIT || !rx_s) hi_cnt <= '0;
      else if (tick && hi_cnt != HI_FULL) hi_cnt <= hi_cnt + CW'(1);
    end
  end

`ifdef UART_RX_CFG_FIFO_EN
  logic                        push_q, full, empty, pop;
  logic [WW-1:0]               word_q;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  assign pop     = m_ready & ~empty;
  assign m_valid = (fifo_cnt != '0);

  // stage the committed word, flag drops on a full FIFO
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      push_q  <= 1'b0;
      word_q  <= '0;
      overrun <= 1'b0;
    end else begin
      push_q  <= commit;
      if (commit) word_q <= c_word;
      overrun <= push_q & full & ~pop;
    end
  end

  uart_rx_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push_q),
    .wdata (word_q),
    .pop   (pop),
    .rdata (head),
    .count (fifo_cnt),
    .full  (full),
    .empty (empty)
  );
`else
  logic [WW-1:0] hold;
  logic          hold_v;

  assign head    = hold;
  assign m_valid = hold_v;

  // single holding register; a commit that finds it occupied is dropped
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold    <= '0;
      hold_v  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit && (!hold_v || m_ready)) begin
        hold   <= c_word;
        hold_v <= 1'b1;
      end else begin
        if (m_ready) hold_v <= 1'b0;
        if (commit)  overrun <= 1'b1;
      end
    end
  end
`endif

  assign {m_break, m_parity_err, m_frame_err, m_data} = head;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg, one 8N1 and one 8E2 instance.
// Expected words come from a frame-level model of the bits put on the line.
module tb_uart_rx_cfg;
  localparam int BIT = 432;
`ifdef UART_RX_CFG_FIFO_EN
  localparam int CAP   = 4;
  localparam int N_OVR = 6;
`else
  localparam int CAP   = 1;
  localparam int N_OVR = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic rdy0 = 1'b1;
  logic rdy1 = 1'b1;
  logic rdy0_set = 1'b1;
  logic rnd0 = 1'b0;
  logic [7:0] d0, d1;
  logic fe0, pe0, bk0, v0, ov0;
  logic fe1, pe1, bk1, v1, ov1;
  logic [10:0] w0, w1, pw0, pw1;
  logic hold0 = 1'b0;
  logic hold1 = 1'b0;
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  int n_tests = 0;
  int n_fail = 0;
  int ovr0 = 0;
  int ovr1 = 0;

  assign w0 = {bk0, pe0, fe0, d0};
  assign w1 = {bk1, pe1, fe1, d1};

  always #10 clk = ~clk;

  uart_rx_cfg #(
    .CLK_FREQ(50_000_000), .UART_BPS(115_200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut0 (
    .sys_clk(clk), .sys_rst(rst), .rx(rx0),
    .m_data(d0), .m_frame_err(fe0), .m_parity_err(pe0), .m_break(bk0),
    .m_valid(v0), .m_ready(rdy0), .overrun(ov0)
  );

  uart_rx_cfg #(
    .CLK_FREQ(50_000_000), .UART_BPS(115_200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut1 (
    .sys_clk(clk), .sys_rst(rst), .rx(rx1),
    .m_data(d1), .m_frame_err(fe1), .m_parity_err(pe1), .m_break(bk1),
    .m_valid(v1), .m_ready(rdy1), .overrun(ov1)
  );

  // frame-level reference: inst0 is 8N1, inst1 is 8 data, even parity, 2 stop
  function automatic logic [10:0] model(input int inst, input logic [7:0] d,
                                        input bit par_bad, input bit s1,
                                        input bit s2);
    bit has_par, two, pbit, pe, fe, brk;
    has_par = (inst == 1);
    two     = (inst == 1);
    pbit    = (^d) ^ par_bad;
    pe      = has_par && (pbit != (^d));
    fe      = !s1 || (two && !s2);
    brk     = (d == 8'h00) && (!has_par || !pbit) && !s1 && (!two || !s2);
    return {brk, pe, fe, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_pop(input int inst, input logic [10:0] act);
    logic [10:0] e;
    n_tests++;
    if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL word%0d: got brk/pe/fe/data %h, expected no word", inst, act);
    end else begin
      if (inst == 0) e = q0.pop_front();
      else           e = q1.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL word%0d: got brk=%b pe=%b fe=%b data=%h expected brk=%b pe=%b fe=%b data=%h",
                 inst, act[10], act[9], act[8], act[7:0], e[10], e[9], e[8], e[7:0]);
      end
    end
  endtask

  task automatic drive(input int inst, input logic v, input int n);
    if (inst == 0) rx0 = v;
    else           rx1 = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d,
                            input bit par_bad, input bit s1, input bit s2,
                            input int gap, input bit push);
    logic [10:0] e;
    e = model(inst, d, par_bad, s1, s2);
    if (push) begin
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
    drive(inst, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(inst, d[i], BIT);
    if (inst == 1) drive(inst, (^d) ^ par_bad, BIT);
    drive(inst, s1, BIT);
    if (inst == 1) drive(inst, s2, BIT);
    drive(inst, 1'b1, gap * BIT);
  endtask

  // ready driver for inst0: fixed level or random per cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy0 = rnd0 ? 1'($urandom_range(0, 1)) : rdy0_set;
    end
  end

  // monitor: pop and compare accepted words, check held words stay put
  always @(negedge clk) begin
    if (rst) begin
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if (hold0) check("stable0", {v0, w0}, {1'b1, pw0});
      if (hold1) check("stable1", {v1, w1}, {1'b1, pw1});
      if (v0 && rdy0) check_pop(0, w0);
      if (v1 && rdy1) check_pop(1, w1);
      if (ov0) ovr0++;
      if (ov1) ovr1++;
      hold0 = v0 && !rdy0;
      hold1 = v1 && !rdy1;
      pw0 = w0;
      pw1 = w1;
    end
  end

  initial begin
    int base;
    logic [7:0] rd;
    bit rs;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_valid0", v0, 0);
    check("rst_word0", w0, 0);
    check("rst_ovr0", ov0, 0);
    check("rst_valid1", v1, 0);
    check("rst_word1", w1, 0);
    check("rst_ovr1", ov1, 0);
    @(posedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    fork
      begin
        send_frame(0, 8'hA5, 0, 1, 1, 2, 1);
        send_frame(0, 8'h55, 0, 0, 1, 2, 1);
        q0.push_back(model(0, 8'h00, 0, 0, 0));
        drive(0, 1'b0, 12 * BIT);
        drive(0, 1'b1, BIT / 2);
        drive(0, 1'b0, BIT);
        drive(0, 1'b1, 3 * BIT);
        drive(0, 1'b0, 81);
        drive(0, 1'b1, 2 * BIT);
        send_frame(0, 8'hC3, 0, 1, 1, 2, 1);
        check("drained_dir0", q0.size(), 0);
        check("no_ovr_dir0", ovr0, 0);
        base = ovr0;
        rdy0_set = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < N_OVR; k++)
          send_frame(0, 8'(17 * (k + 1)), 0, 1, 1, 0, k < CAP);
        drive(0, 1'b1, BIT);
        @(negedge clk);
        check("held_valid", v0, 1);
        check("held_data", d0, 8'h11);
        check("ovr_count", ovr0 - base, N_OVR - CAP);
        rdy0_set = 1'b1;
        repeat (20) @(posedge clk);
        check("drained_ovr", q0.size(), 0);
      end
      begin
        send_frame(1, 8'h3C, 1, 1, 1, 2, 1);
        send_frame(1, 8'h3C, 0, 1, 1, 2, 1);
        send_frame(1, 8'hA5, 0, 1, 0, 2, 1);
        send_frame(1, 8'h00, 0, 0, 0, 2, 1);
        for (int k = 0; k < 3; k++) begin
          rd = 8'($urandom);
          send_frame(1, rd, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2, 1);
        end
        repeat (20) @(posedge clk);
        check("drained1", q1.size(), 0);
      end
    join

    base = ovr0;
    rnd0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd = 8'($urandom);
      rs = $urandom_range(0, 3) != 0;
      send_frame(0, rd, 0, rs, 1, 2, 1);
    end
    rnd0 = 1'b0;
    repeat (20) @(posedge clk);
    check("drained_rnd0", q0.size(), 0);
    check("no_ovr_rnd0", ovr0 - base, 0);

    base = ovr0;
    drive(0, 1'b0, BIT);
    drive(0, 1'b1, BIT);
    for (int i = 0; i < 3; i++) drive(0, 1'b0, BIT);
    drive(0, 1'b0, BIT / 2);
    rst = 1'b1;
    rx0 = 1'b1;
    repeat (4) @(posedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 2 * BIT);
    send_frame(0, 8'h42, 0, 1, 1, 2, 1);
    repeat (20) @(posedge clk);
    check("drained_rst", q0.size(), 0);
    check("no_ovr_rst", ovr0 - base, 0);
    check("no_ovr1", ovr1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
